fetch_unit: RTL

//  Instruction-fetch front end sitting between the BPU and the I-cache. Holds the fetch PC and

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// A fetch bundle is what travels from the I-cache response to decode.
package fetch_unit_pkg;

  localparam logic [31:0] BOOT_PC_DEFAULT = 32'h8000_0000;
  localparam int          FETCH_W         = 64;

  localparam logic [1:0] TAKEN_NONE = 2'b00;
  localparam logic [1:0] TAKEN_LOW  = 2'b01;
  localparam logic [1:0] TAKEN_HIGH = 2'b10;

  typedef struct packed {
    logic [31:0]        pc;
    logic [FETCH_W-1:0] instr;
    logic [1:0]         mask;
    logic [1:0]         taken;
    logic               fault;
  } fetch_bundle_t;

  // An unaligned PC skips the low slot; a low-word taken branch kills the high slot.
  function automatic logic [1:0] slot_mask(input logic [31:0] pc, input logic [1:0] taken);
    return {taken != TAKEN_LOW, ~pc[2]};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small bundle FIFO with flush and occupancy count; head entry is read straight
// from the storage registers so the outputs never depend on this cycle's inputs.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic                         valid_o,
  output logic [WIDTH-1:0]             data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0) && !flush_i;
  assign do_push = push_i && (!full || do_pop) && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, issues one I-cache request at a time when
// the bundle FIFO has room, and drops responses made stale by a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] BOOT_PC    = BOOT_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               branch_request_i,
  input  logic [31:0]        branch_pc_i,
  input  logic [31:0]        bpu_next_pc_i,
  input  logic [1:0]         bpu_next_taken_i,
  output logic [31:0]        pc_f_o,
  output logic               pc_accept_o,
  output logic               icache_rd_o,
  output logic [31:0]        icache_pc_o,
  input  logic               icache_accept_i,
  input  logic               icache_valid_i,
  input  logic [FETCH_W-1:0] icache_inst_i,
  input  logic               icache_error_i,
  output logic               fetch_valid_o,
  output logic [31:0]        fetch_pc_o,
  output logic [FETCH_W-1:0] fetch_instr_o,
  output logic [1:0]         fetch_mask_o,
  output logic [1:0]         fetch_taken_o,
  output logic               fetch_fault_o,
  input  logic               fetch_accept_i
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  logic [31:0]   pc_q, pc_d, req_pc_q, req_pc_d;
  logic [1:0]    req_taken_q, req_taken_d;
  logic          busy_q, busy_d, drop_q, drop_d;
  logic [CNT_W-1:0] fifo_count;
  logic          issue_ok, rsp_fire, push, pop, head_valid;
  fetch_bundle_t push_bundle, head_bundle;

  // The outstanding request reserves a FIFO slot, so a response can always be pushed.
  assign issue_ok    = !busy_q && ((int'(fifo_count) + int'(busy_q)) < FIFO_DEPTH) && !branch_request_i;
  assign icache_rd_o = issue_ok && !rst_i;
  assign pc_accept_o = icache_rd_o && icache_accept_i;
  assign rsp_fire    = icache_valid_i && busy_q;
  assign push        = rsp_fire && !drop_q && !branch_request_i;
  assign pop         = head_valid && fetch_accept_i;

  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_taken_d = req_taken_q;
    busy_d      = busy_q;
    drop_d      = drop_q;
    if (rsp_fire) begin
      busy_d = 1'b0;
      drop_d = 1'b0;
    end
    if (pc_accept_o) begin
      pc_d        = bpu_next_pc_i;
      req_pc_d    = pc_q;
      req_taken_d = bpu_next_taken_i;
      busy_d      = 1'b1;
    end
    if (branch_request_i) begin
      pc_d = branch_pc_i;
      if (busy_q && !icache_valid_i) drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q        <= BOOT_PC;
      req_pc_q    <= '0;
      req_taken_q <= TAKEN_NONE;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_taken_q <= req_taken_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    push_bundle.pc    = req_pc_q;
    push_bundle.instr = icache_inst_i;
    push_bundle.mask  = slot_mask(req_pc_q, req_taken_q);
    push_bundle.taken = req_taken_q;
    push_bundle.fault = icache_error_i;
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_bundle_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (branch_request_i),
    .push_i  (push),
    .data_i  (push_bundle),
    .pop_i   (pop),
    .valid_o (head_valid),
    .data_o  (head_bundle),
    .count_o (fifo_count)
  );

  assign pc_f_o        = pc_q;
  assign icache_pc_o   = {pc_q[31:3], 3'b000};
  assign fetch_valid_o = head_valid;
  assign fetch_pc_o    = head_bundle.pc;
  assign fetch_instr_o = head_bundle.instr;
  assign fetch_mask_o  = head_bundle.mask;
  assign fetch_taken_o = head_bundle.taken;
  assign fetch_fault_o = head_bundle.fault;

endmodule
